// File: rtl/avalon_mm_pwm_capture.sv
// Four-channel PWM period / high-time capture behind an Avalon-MM register interface.
// Each input is synchronised and edge-detected, then timed by a prescaled per-channel counter.
`timescale 1ns/1ps
module avalon_mm_pwm_capture (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  output logic [15:0] readdata,
  input  logic        write,
  input  logic [15:0] writedata,
  input  logic [3:0]  pwm_in
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HIGH = 2'd1, ST_LOW = 2'd2} state_t;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [3:0]  sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
  logic [1:0]  settle_q, settle_d;
  logic [7:0]  divider_q, divider_d;
  logic [3:0]  enable_q, enable_d;
  logic [7:0]  status_q, status_d;
  logic [15:0] readdata_q, readdata_d;
  logic [7:0]  pre_q [4];
  logic [7:0]  pre_d [4];
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  logic [15:0] shadow_q [4];
  logic [15:0] shadow_d [4];
  logic [15:0] period_q [4];
  logic [15:0] period_d [4];
  logic [15:0] high_q [4];
  logic [15:0] high_d [4];
  logic [15:0] captured [4];
  state_t      state_q [4];
  state_t      state_d [4];
  logic [3:0]  rise, fall, tick, latch_high, publish, ovf_set;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[15:8];

  // Edges are ignored until the synchroniser has refilled after reset, so a pin
  // that is already high when reset drops never looks like a rising edge.
  always_comb begin
    sync1_d  = pwm_in;
    sync2_d  = sync1_q;
    edge_d   = sync2_q;
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    rise     = (settle_q == 2'd3) ? (sync2_q & ~edge_q) : 4'h0;
    fall     = (settle_q == 2'd3) ? (~sync2_q & edge_q) : 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick[i]     = (pre_q[i] == divider_q);
      captured[i] = (tick[i] && cnt_q[i] != CNT_MAX) ? cnt_q[i] + 16'd1 : cnt_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) state_q[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < 4; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      if (!enable_q[i]) begin
        state_d[i] = ST_IDLE;
      end else begin
        case (state_q[i])
          ST_IDLE: if (rise[i]) state_d[i] = ST_HIGH;
          ST_HIGH: begin
            if (cnt_q[i] == CNT_MAX) state_d[i] = ST_IDLE;
            else if (fall[i])        state_d[i] = ST_LOW;
          end
          ST_LOW: begin
            if (cnt_q[i] == CNT_MAX) state_d[i] = ST_IDLE;
            else if (rise[i])        state_d[i] = ST_HIGH;
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    latch_high = '0;
    publish    = '0;
    ovf_set    = '0;
    for (int i = 0; i < 4; i++) begin
      if (enable_q[i]) begin
        case (state_q[i])
          ST_HIGH: begin
            if (cnt_q[i] == CNT_MAX) ovf_set[i]    = 1'b1;
            else if (fall[i])        latch_high[i] = 1'b1;
          end
          ST_LOW: begin
            if (cnt_q[i] == CNT_MAX) ovf_set[i] = 1'b1;
            else if (rise[i])        publish[i] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (!enable_q[i] || rise[i] || tick[i]) pre_d[i] = 8'h00;
      else                                   pre_d[i] = pre_q[i] + 8'd1;

      if (!enable_q[i] || rise[i])
        cnt_d[i] = 16'h0000;
      else if (state_q[i] != ST_IDLE && tick[i] && cnt_q[i] != CNT_MAX)
        cnt_d[i] = cnt_q[i] + 16'd1;
      else
        cnt_d[i] = cnt_q[i];

      shadow_d[i] = latch_high[i] ? captured[i] : shadow_q[i];
      period_d[i] = publish[i]    ? captured[i] : period_q[i];
      high_d[i]   = publish[i]    ? shadow_q[i] : high_q[i];
    end
  end

  // Hardware sets are OR-ed in after the write-1-to-clear mask so they win a collision.
  always_comb begin
    divider_d = divider_q;
    enable_d  = enable_q;
    if (write && address == 4'd8)  divider_d = writedata[7:0];
    if (write && address == 4'd10) enable_d  = writedata[3:0];
    status_d = (status_q & ~((write && address == 4'd9) ? writedata[7:0] : 8'h00))
             | {ovf_set, publish};

    readdata_d = readdata_q;
    if (read) begin
      case (address)
        4'd0, 4'd1, 4'd2, 4'd3: readdata_d = period_q[address[1:0]];
        4'd4, 4'd5, 4'd6, 4'd7: readdata_d = high_q[address[1:0]];
        4'd8:    readdata_d = {8'h00, divider_q};
        4'd9:    readdata_d = {8'h00, status_q};
        4'd10:   readdata_d = {12'h000, enable_q};
        default: readdata_d = 16'h0000;
      endcase
    end
  end

  assign readdata = readdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      edge_q     <= '0;
      settle_q   <= '0;
      divider_q  <= '0;
      enable_q   <= '0;
      status_q   <= '0;
      readdata_q <= '0;
      for (int i = 0; i < 4; i++) begin
        pre_q[i]    <= '0;
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
        period_q[i] <= '0;
        high_q[i]   <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_q     <= edge_d;
      settle_q   <= settle_d;
      divider_q  <= divider_d;
      enable_q   <= enable_d;
      status_q   <= status_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < 4; i++) begin
        pre_q[i]    <= pre_d[i];
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
        period_q[i] <= period_d[i];
        high_q[i]   <= high_d[i];
      end
    end
  end
endmodule
